// File: rtl/term_drain_arb.sv
// Round-robin drain arbiter: collects one packet at a time from N terminal FIFOs.
// Optional destination check enabled by defining TERM_DRAIN_DST_CHECK_EN.
module term_drain_arb #(
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLUMS    = 4,
  parameter int unsigned PCK_SZ    = 40,
  parameter int unsigned DST_MSB   = 31,
  parameter int unsigned DST_LSB   = 26,
  parameter int unsigned STALL_MAX = 128,
  localparam int unsigned N        = 2*ROWS + 2*COLUMS,
  localparam int unsigned IW       = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [N-1:0]      pndng,
  input  logic [PCK_SZ-1:0] data_out [N],
  output logic [N-1:0]      pop,
  output logic [PCK_SZ-1:0] pkt,
  output logic [IW-1:0]     pkt_src,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic              dst_err,
  output logic              stall_err
);

  localparam int unsigned SW      = $clog2(STALL_MAX + 1);
  localparam logic [IW:0] N_W     = (IW+1)'(N);
  localparam logic [SW-1:0] SMAX  = SW'(STALL_MAX);

  if (DST_MSB < DST_LSB || DST_MSB >= PCK_SZ) begin : g_bad_dst_field
    $error("term_drain_arb: destination field outside packet");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     g_q, g_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic [PCK_SZ-1:0] pkt_d;
  logic [IW-1:0]     src_d;
  logic              valid_d;
  logic              serr_d;
  logic              sel_found;
  logic [IW-1:0]     sel_idx;
  logic [IW-1:0]     cand;
  logic [PCK_SZ-1:0] head;

  function automatic logic [IW-1:0] ring_add(input logic [IW-1:0] base, input logic [IW:0] off);
    logic [IW:0] s;
    s = {1'b0, base} + off;
    if (s >= N_W) s = s - N_W;
    return s[IW-1:0];
  endfunction

  assign head = data_out[g_q];

  // First pending terminal at or after rr_q, walking the ring once
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = ring_add(rr_q, (IW+1)'(k));
      if (!sel_found && pndng[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Pop is qualified by the live pndng so a withdrawn request never dequeues
  assign pop = (state_q == GRANT && !reset) ? (pndng & (N'(1) << g_q)) : '0;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    pkt_d   = pkt;
    src_d   = pkt_src;
    valid_d = pkt_valid;
    case (state_q)
      IDLE: begin
        if (en && sel_found) begin
          g_d     = sel_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (pndng[g_q]) begin
          pkt_d   = head;
          src_d   = g_q;
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (pkt_ready) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          rr_d    = ring_add(g_q, (IW+1)'(1));
          state_d = IDLE;
        end else if (cnt_q != SMAX) begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    serr_d = stall_err | (cnt_d == SMAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      g_q       <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      pkt       <= '0;
      pkt_src   <= '0;
      pkt_valid <= 1'b0;
      stall_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      pkt       <= pkt_d;
      pkt_src   <= src_d;
      pkt_valid <= valid_d;
      stall_err <= serr_d;
    end
  end

`ifdef TERM_DRAIN_DST_CHECK_EN
  localparam int unsigned DW = DST_MSB - DST_LSB + 1;
  logic dst_q;

  // Mismatch is judged once at capture and held while the packet is offered
  always_ff @(posedge clk) begin
    if (reset) begin
      dst_q <= 1'b0;
    end else if (state_q == GRANT && pndng[g_q]) begin
      dst_q <= (head[DST_MSB:DST_LSB] != DW'(g_q));
    end else if (state_q == HOLD && pkt_ready) begin
      dst_q <= 1'b0;
    end
  end
  assign dst_err = dst_q;
`else
  assign dst_err = 1'b0;
`endif

endmodule

// File: tb/tb_term_drain_arb.sv
// Self-checking bench for term_drain_arb: FIFO queues, per-cycle reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_term_drain_arb;
  localparam int N         = 16;
  localparam int PW        = 40;
  localparam int STALL_MAX = 128;
  typedef logic [PW-1:0] pkt_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [N-1:0]  pndng;
  pkt_t          data_out [N];
  logic [N-1:0]  pop;
  pkt_t          pkt;
  logic [3:0]    pkt_src;
  logic          pkt_valid;
  logic          pkt_ready;
  logic          dst_err;
  logic          stall_err;

  always #5 clk = ~clk;

  term_drain_arb dut (
    .clk(clk), .reset(reset), .en(en), .pndng(pndng), .data_out(data_out),
    .pop(pop), .pkt(pkt), .pkt_src(pkt_src), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready), .dst_err(dst_err), .stall_err(stall_err)
  );

  pkt_t         fifo [N][$];
  logic [N-1:0] mask;
  int           n_chk = 0;
  int           n_err = 0;
  int           cyc = 0;
  bit           chk_on = 0;

  // Reference model: where the current transfer is, who owns it, what was collected
  int   m_ph = 0;      // 0 waiting, 1 pop due, 2 offering packet
  int   m_g = 0;
  int   m_rr = 0;
  pkt_t m_pkt = '0;
  int   m_src = 0;
  bit   m_valid = 0;
  int   m_cnt = 0;
  bit   m_serr = 0;
  bit   m_dst = 0;

  // Event logs gathered by run()
  int   pop_idx[$];
  int   pop_t[$];
  int   vld_t[$];
  int   vld_src[$];
  pkt_t vld_pkt[$];
  bit   vld_dst[$];
  int   st_t;
  bit   prev_v;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic pkt_t mk_pkt(int t, bit bad);
    pkt_t p;
    p = PW'({$urandom, $urandom});
    p[31:26] = bad ? (6'(t) ^ 6'(1 + $urandom_range(62, 0))) : 6'(t);
    return p;
  endfunction

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      pndng[i]    = (fifo[i].size() != 0) && !mask[i];
      data_out[i] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
    end
  endtask

  task automatic tick();
    refresh();
    @(posedge clk);
    #1;
    cyc++;
    refresh();
  endtask

  task automatic clear_logs();
    pop_idx.delete(); pop_t.delete(); vld_t.delete();
    vld_src.delete(); vld_pkt.delete(); vld_dst.delete();
    st_t = -1;
    prev_v = 1'b0;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      tick();
      #2;
      for (int i = 0; i < N; i++)
        if (pop[i]) begin pop_idx.push_back(i); pop_t.push_back(cyc); end
      if (pkt_valid && !prev_v) begin
        vld_t.push_back(cyc); vld_src.push_back(int'(pkt_src));
        vld_pkt.push_back(pkt); vld_dst.push_back(dst_err);
      end
      if (stall_err && st_t < 0) st_t = cyc;
      prev_v = pkt_valid;
    end
  endtask

  task automatic clear_all();
    reset = 1'b1;
    for (int i = 0; i < N; i++) fifo[i].delete();
    mask = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  // Model advance on each clock edge, from the inputs presented in that cycle
  always @(posedge clk) begin
    if (reset) begin
      m_ph = 0; m_rr = 0; m_valid = 0; m_pkt = '0; m_src = 0;
      m_cnt = 0; m_serr = 0; m_dst = 0; m_g = 0;
      chk_on = 1'b1;
    end else begin
      case (m_ph)
        0: if (en && pndng != '0) begin
          bit found;
          found = 1'b0;
          for (int k = 0; k < N; k++)
            if (!found && pndng[(m_rr + k) % N]) begin
              found = 1'b1;
              m_g = (m_rr + k) % N;
            end
          m_ph = 1;
        end
        1: if (pndng[m_g]) begin
          m_pkt = data_out[m_g];
          m_src = m_g;
          m_valid = 1'b1;
`ifdef TERM_DRAIN_DST_CHECK_EN
          m_dst = (int'(data_out[m_g][31:26]) != m_g);
`else
          m_dst = 1'b0;
`endif
          void'(fifo[m_g].pop_front());
          m_ph = 2;
        end else begin
          m_ph = 0;
        end
        default: if (pkt_ready) begin
          m_valid = 1'b0; m_dst = 1'b0; m_cnt = 0;
          m_rr = (m_g + 1) % N;
          m_ph = 0;
        end else if (m_cnt < STALL_MAX) begin
          m_cnt++;
          if (m_cnt == STALL_MAX) m_serr = 1'b1;
        end
      endcase
    end
  end

  // Compare process: every cycle, mid-period
  always @(negedge clk) begin
    if (chk_on) begin
      logic [N-1:0] e_pop;
      e_pop = '0;
      if (m_ph == 1 && !reset && pndng[m_g]) e_pop[m_g] = 1'b1;
      chk("pop", 64'(pop), 64'(e_pop));
      chk("pkt_valid", 64'(pkt_valid), 64'(m_valid));
      if (m_valid) begin
        chk("pkt", 64'(pkt), 64'(m_pkt));
        chk("pkt_src", 64'(pkt_src), 64'(m_src));
      end
      chk("stall_err", 64'(stall_err), 64'(m_serr));
      chk("dst_err", 64'(dst_err), 64'(m_dst));
    end
  end

  initial begin
    pkt_t p;
    reset = 1'b1; en = 1'b0; pkt_ready = 1'b1; mask = '0;
    clear_logs();
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    #2;
    chk("rst_pkt", 64'(pkt), 64'(0));
    chk("rst_pkt_src", 64'(pkt_src), 64'(0));
    chk("rst_pkt_valid", 64'(pkt_valid), 64'(0));
    chk("rst_pop", 64'(pop), 64'(0));
    chk("rst_stall_err", 64'(stall_err), 64'(0));
    chk("rst_dst_err", 64'(dst_err), 64'(0));

    // Single request from terminal 5
    en = 1'b1; pkt_ready = 1'b1;
    p = mk_pkt(5, 1'b0);
    fifo[5].push_back(p);
    clear_logs();
    run(8);
    chk("single_pop_count", 64'(pop_idx.size()), 64'(1));
    chk("single_vld_count", 64'(vld_t.size()), 64'(1));
    if (pop_idx.size() == 1 && vld_t.size() == 1) begin
      chk("single_pop_idx", 64'(pop_idx[0]), 64'(5));
      chk("single_latency", 64'(vld_t[0] - pop_t[0]), 64'(1));
      chk("single_src", 64'(vld_src[0]), 64'(5));
      chk("single_pkt", 64'(vld_pkt[0]), 64'(p));
      chk("single_dst_err", 64'(vld_dst[0]), 64'(0));
    end

    // Fairness: everyone requesting, pointer starts at 0
    clear_all();
    for (int i = 0; i < N; i++) begin
      fifo[i].push_back(mk_pkt(i, 1'b0));
      fifo[i].push_back(mk_pkt(i, 1'b0));
    end
    clear_logs();
    run(55);
    chk("fair_enough_pops", 64'(pop_idx.size() >= 17), 64'(1));
    if (pop_idx.size() >= 17)
      for (int k = 0; k < 17; k++) begin
        chk("fair_order", 64'(pop_idx[k]), 64'(k % 16));
        if (k > 0) chk("fair_spacing", 64'(pop_t[k] - pop_t[k-1]), 64'(3));
      end

    // Wrap: park pointer at 15 by serving 14, then 15 and 2 compete
    clear_all();
    fifo[14].push_back(mk_pkt(14, 1'b0));
    run(6);
    fifo[15].push_back(mk_pkt(15, 1'b0));
    fifo[2].push_back(mk_pkt(2, 1'b0));
    clear_logs();
    run(10);
    chk("wrap_count", 64'(pop_idx.size()), 64'(2));
    if (pop_idx.size() == 2) begin
      chk("wrap_first", 64'(pop_idx[0]), 64'(15));
      chk("wrap_second", 64'(pop_idx[1]), 64'(2));
    end

    // Back-pressure for 140 cycles
    clear_all();
    pkt_ready = 1'b0;
    p = mk_pkt(9, 1'b0);
    fifo[9].push_back(p);
    fifo[10].push_back(mk_pkt(10, 1'b0));
    clear_logs();
    run(140);
    chk("bp_pop_count", 64'(pop_idx.size()), 64'(1));
    chk("bp_vld_count", 64'(vld_t.size()), 64'(1));
    chk("bp_pkt_held", 64'(pkt), 64'(p));
    if (vld_t.size() == 1) chk("bp_stall_onset", 64'(st_t - vld_t[0]), 64'(STALL_MAX));
    pkt_ready = 1'b1;
    run(1);
    chk("bp_handshake_valid", 64'(pkt_valid), 64'(0));
    chk("bp_stall_sticky", 64'(stall_err), 64'(1));
    clear_all();
    #2;
    chk("bp_stall_cleared", 64'(stall_err), 64'(0));

    // Request withdrawn while granted
    fifo[3].push_back(mk_pkt(3, 1'b0));
    tick();
    mask[3] = 1'b1;
    refresh();
    #2;
    chk("withdraw_pop", 64'(pop), 64'(0));
    clear_logs();
    run(4);
    chk("withdraw_no_pop", 64'(pop_idx.size()), 64'(0));
    chk("withdraw_no_valid", 64'(vld_t.size()), 64'(0));
    mask[3] = 1'b0;
    run(6);
    chk("withdraw_later_pop", 64'(pop_idx.size()), 64'(1));

    // Reset while offering a packet
    clear_all();
    pkt_ready = 1'b0;
    fifo[11].push_back(mk_pkt(11, 1'b0));
    run(4);
    chk("hold_before_reset", 64'(pkt_valid), 64'(1));
    fifo[12].push_back(mk_pkt(12, 1'b0));
    reset = 1'b1;
    tick();
    #2;
    chk("reset_hold_valid", 64'(pkt_valid), 64'(0));
    chk("reset_hold_pop", 64'(pop), 64'(0));
    tick();
    #2;
    chk("reset_still_no_pop", 64'(pop), 64'(0));
    reset = 1'b0; pkt_ready = 1'b1;
    run(8);

`ifdef TERM_DRAIN_DST_CHECK_EN
    // Terminal 7 carrying destination 4
    clear_all();
    pkt_ready = 1'b0;
    p = mk_pkt(7, 1'b0);
    p[31:26] = 6'd4;
    fifo[7].push_back(p);
    run(5);
    chk("dst_err_hold", 64'(dst_err), 64'(1));
    chk("dst_src", 64'(pkt_src), 64'(7));
    chk("dst_valid", 64'(pkt_valid), 64'(1));
    pkt_ready = 1'b1;
    run(2);
    chk("dst_delivered", 64'(pkt_valid), 64'(0));
`endif

    // Randomized traffic
    clear_all();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3, 0) == 0) begin
        int t;
        bit bad;
        t = $urandom_range(N - 1, 0);
`ifdef TERM_DRAIN_DST_CHECK_EN
        bad = ($urandom_range(3, 0) == 0);
`else
        bad = 1'b0;
`endif
        if (fifo[t].size() < 4) fifo[t].push_back(mk_pkt(t, bad));
      end
      en        = ($urandom_range(7, 0) != 0);
      pkt_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(15, 0) == 0) mask = N'($urandom & $urandom & $urandom);
      reset     = ($urandom_range(499, 0) == 0);
      tick();
    end
    reset = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
